// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register, imem req/ack fetch FSM and IF_ID output registers.
// Optional IF_FLUSH_NOP_EN: each redirect also writes a NOP bubble (Instrucction=0, PC_4=0).
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_4,
    output logic [31:0] Instrucction,
    output logic        fetch_valid
);
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
    state_t      state;
    logic [31:0] pc, held, target, pc_next;
    logic        redirect;
    assign redirect  = jump | branch_taken;
    assign target    = (jump ? jump_target : branch_target) & ~32'h3;
    assign pc_next   = pc + 32'd4;
    assign imem_addr = pc;
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            state        <= FETCH;
            imem_req     <= 1'b0;
            PC_4         <= 32'h0;
            Instrucction <= 32'h0;
            fetch_valid  <= 1'b0;
            held         <= 32'h0;
        end else begin
            if (!stall) fetch_valid <= 1'b0;
            if (redirect) begin
                fetch_valid <= 1'b0;
                pc          <= target;
`ifdef IF_FLUSH_NOP_EN
                Instrucction <= 32'h0;
                PC_4         <= 32'h0;
`endif
            end
            case (state)
                FETCH: begin
                    if (imem_req && imem_ack) begin
                        if (!redirect && !stall) begin
                            Instrucction <= imem_rdata;
                            PC_4         <= pc_next;
                            fetch_valid  <= 1'b1;
                            pc           <= pc_next;
                        end else if (!redirect) begin
                            held     <= imem_rdata;
                            state    <= HOLD;
                            imem_req <= 1'b0;
                        end
                    end else if (imem_req && redirect) begin
                        // request still outstanding: its ack must be swallowed
                        state    <= DISCARD;
                        imem_req <= 1'b0;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end else if (!stall) begin
                        Instrucction <= held;
                        PC_4         <= pc_next;
                        fetch_valid  <= 1'b1;
                        pc           <= pc_next;
                        state        <= FETCH;
                        imem_req     <= 1'b1;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= FETCH;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed checks of fetch, stall/hold, discard, redirect priority and PC wrap.
module tb_if_fetch_stage;
    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump, imem_ack, ack2;
    logic [31:0] branch_target, jump_target, imem_rdata, rdata2;
    logic        imem_req, fetch_valid, req2, fv2;
    logic [31:0] imem_addr, PC_4, Instrucction, addr2, pc4_2, instr2;
    logic [31:0] flush_instr;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    if_fetch_stage u_dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .PC_4(PC_4), .Instrucction(Instrucction), .fetch_valid(fetch_valid)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2),
        .PC_4(pc4_2), .Instrucction(instr2), .fetch_valid(fv2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        check("req_in_reset", {31'b0, imem_req}, 32'h0);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        {stall, branch_taken, jump, imem_ack, ack2} = '0;
        {branch_target, jump_target, imem_rdata, rdata2} = '0;
`ifdef IF_FLUSH_NOP_EN
        flush_instr = 32'h0;
`else
        flush_instr = 32'hAA;
`endif
        do_reset();
        check("rst_req", {31'b0, imem_req}, 32'h1);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_pc4", PC_4, 32'h0);
        check("rst_instr", Instrucction, 32'h0);
        check("rst_fv", {31'b0, fetch_valid}, 32'h0);

        // back-to-back acks, one word per cycle
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("seq_addr", imem_addr, 32'(4 * i));
            imem_rdata = 32'(17 * (i + 1));
            tick();
            check("seq_pc4", PC_4, 32'(4 * (i + 1)));
            check("seq_instr", Instrucction, 32'(17 * (i + 1)));
            check("seq_fv", {31'b0, fetch_valid}, 32'h1);
            check("seq_req", {31'b0, imem_req}, 32'h1);
        end
        imem_ack = 1'b0;

        // stall on ack at 0x4
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'h11;
        tick();
        check("st_addr", imem_addr, 32'h4);
        imem_rdata = 32'hAA; stall = 1'b1;
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("hold_req", {31'b0, imem_req}, 32'h0);
            check("hold_pc4", PC_4, 32'h4);
            check("hold_instr", Instrucction, 32'h11);
            check("hold_fv", {31'b0, fetch_valid}, 32'h1);
            if (i < 2) tick();
        end
        stall = 1'b0;
        tick();
        check("rel_instr", Instrucction, 32'hAA);
        check("rel_pc4", PC_4, 32'h8);
        check("rel_fv", {31'b0, fetch_valid}, 32'h1);
        check("rel_req", {31'b0, imem_req}, 32'h1);
        check("rel_addr", imem_addr, 32'h8);
        tick();
        check("consume_fv", {31'b0, fetch_valid}, 32'h0);
        check("consume_pc4", PC_4, 32'h8);

        // branch while waiting -> DISCARD
        branch_taken = 1'b1; branch_target = 32'h103;
        tick();
        branch_taken = 1'b0;
        check("dis_req", {31'b0, imem_req}, 32'h0);
        check("dis_addr", imem_addr, 32'h100);
        tick();
        check("dis_wait_req", {31'b0, imem_req}, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD;
        tick();
        imem_ack = 1'b0;
        check("dis_done_req", {31'b0, imem_req}, 32'h1);
        check("dis_done_addr", imem_addr, 32'h100);
        check("dis_instr", Instrucction, flush_instr);
        check("dis_fv", {31'b0, fetch_valid}, 32'h0);

        // jump beats branch in the ack cycle
        imem_ack = 1'b1; imem_rdata = 32'h55;
        jump = 1'b1; jump_target = 32'h200;
        branch_taken = 1'b1; branch_target = 32'h300;
        tick();
        jump = 1'b0; branch_taken = 1'b0;
        check("jmp_fv", {31'b0, fetch_valid}, 32'h0);
        check("jmp_addr", imem_addr, 32'h200);
        check("jmp_req", {31'b0, imem_req}, 32'h1);
        check("jmp_instr", Instrucction, flush_instr);
        imem_rdata = 32'h66;
        tick();
        imem_ack = 1'b0;
        check("post_jmp_pc4", PC_4, 32'h204);
        check("post_jmp_instr", Instrucction, 32'h66);

        // PC wrap from 0xFFFF_FFFC
        do_reset();
        check("wrap_addr0", addr2, 32'hFFFF_FFFC);
        ack2 = 1'b1; rdata2 = 32'h77;
        tick();
        ack2 = 1'b0;
        check("wrap_pc4", pc4_2, 32'h0);
        check("wrap_addr", addr2, 32'h0);
        check("wrap_instr", instr2, 32'h77);
        check("wrap_fv", {31'b0, fv2}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
